// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide, XLEN+1 cycle latency.
// Ports: clk, rst, start/in_ready (issue), funct3, op_a, op_b, kill, out_valid/out_ready, result, busy.
// Optional macro MULDIV_EARLY_OUT_EN: 1-cycle completion for div-by-zero, signed overflow, multiply by 0.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] CNT0 = CW'(XLEN);
  localparam logic [CW-1:0] CNT1 = CW'(1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          r_state;
  logic [2:0]      r_f3;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_m;
  logic [XLEN-1:0] r_result;
  logic [CW-1:0]   r_cnt;
  logic            r_negp;
  logic            r_negr;
  logic            r_dz;
  logic            r_valid;

  logic            w_sa;
  logic            w_sb;
  logic            w_na;
  logic            w_nb;
  logic [XLEN-1:0] w_ma;
  logic [XLEN-1:0] w_mb;
  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_sh;
  logic            w_ge;
  logic [XLEN-1:0] w_sub;
  logic [2*XLEN-1:0] w_sprod;
  logic [XLEN-1:0] w_q;
  logic [XLEN-1:0] w_r;
  logic [XLEN-1:0] w_sel;

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = r_valid;
  assign result    = r_result;

  // Operand signedness: MULHU/DIVU/REMU unsigned, MULHSU signs only op_a.
  assign w_sa = (funct3[1:0] != 2'b11) && (funct3 != 3'b101);
  assign w_sb = w_sa && (funct3 != 3'b010);
  assign w_na = w_sa && op_a[XLEN-1];
  assign w_nb = w_sb && op_b[XLEN-1];
  assign w_ma = w_na ? -op_a : op_a;
  assign w_mb = w_nb ? -op_b : op_b;

  // Multiply: r_hi:r_lo is the accumulator, r_lo starts as the multiplier.
  assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);

  // Divide: r_hi is the partial remainder, r_lo shifts dividend out and quotient in.
  assign w_sh  = {r_hi, r_lo[XLEN-1]};
  assign w_ge  = (w_sh >= {1'b0, r_m});
  assign w_sub = w_sh[XLEN-1:0] - r_m;

  assign w_sprod = r_negp ? -{r_hi, r_lo} : {r_hi, r_lo};
  // A zero divisor naturally yields all-ones magnitude; the sign must not touch it.
  assign w_q = r_dz ? '1 : (r_negp ? -r_lo : r_lo);
  assign w_r = r_negr ? -r_hi : r_hi;

  always_comb begin
    w_sel = w_r;
    unique case (r_f3)
      3'b000:                 w_sel = w_sprod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_sel = w_sprod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_sel = w_q;
      default:                w_sel = w_r;
    endcase
  end

`ifdef MULDIV_EARLY_OUT_EN
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  logic            w_mz;
  logic            w_dz;
  logic            w_ovf;
  logic            w_early;
  logic [XLEN-1:0] w_spec;

  always_comb begin
    w_mz    = !funct3[2] && ((op_a == '0) || (op_b == '0));
    w_dz    = funct3[2] && (op_b == '0);
    w_ovf   = funct3[2] && !funct3[0] && (op_a == MIN) && (op_b == '1);
    w_early = w_mz || w_dz || w_ovf;
    w_spec  = '0;
    if (w_dz)
      w_spec = funct3[1] ? op_a : '1;
    else if (w_ovf)
      w_spec = funct3[1] ? '0 : MIN;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_f3     <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_m      <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_negp   <= 1'b0;
      r_negr   <= 1'b0;
      r_dz     <= 1'b0;
      r_valid  <= 1'b0;
    end else if (kill) begin
      if (r_state != IDLE) begin
        r_state <= IDLE;
        r_valid <= 1'b0;
      end
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_f3   <= funct3;
            r_negp <= w_na ^ w_nb;
            r_negr <= w_na;
            r_dz   <= funct3[2] && (op_b == '0);
            r_cnt  <= CNT0;
            r_hi   <= '0;
            r_lo   <= funct3[2] ? w_ma : w_mb;
            r_m    <= funct3[2] ? w_mb : w_ma;
`ifdef MULDIV_EARLY_OUT_EN
            if (w_early) begin
              r_result <= w_spec;
              r_valid  <= 1'b1;
              r_state  <= DONE;
            end else begin
              r_state <= CALC;
            end
`else
            r_state <= CALC;
`endif
          end
        end
        CALC: begin
          if (r_f3[2]) begin
            r_hi <= w_ge ? w_sub : w_sh[XLEN-1:0];
            r_lo <= {r_lo[XLEN-2:0], w_ge};
          end else begin
            r_hi <= w_sum[XLEN:1];
            r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
          end
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT1)
            r_state <= FIX;
        end
        FIX: begin
          r_result <= w_sel;
          r_valid  <= 1'b1;
          r_state  <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule
